if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_if.sv | 30 +++
 rtl/if_fetch.sv | 74 +++++++
 tb/tb_if_fetch.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: the byte-wide memory read port, the IF/ID handshake
// (stall) and the redirect request, all grouped so the fetch unit and its
// environment connect through one port.
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              stall_i;
  logic              branch_en_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_valid_i;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;

  // Fetch unit side
  modport master (
    input  stall_i, branch_en_i, branch_target_i, mem_rdata_i, mem_valid_i,
    output mem_req_o, mem_addr_o, if_pc, if_inst, if_valid
  );

  // Memory / pipeline side
  modport slave (
    output stall_i, branch_en_i, branch_target_i, mem_rdata_i, mem_valid_i,
    input  mem_req_o, mem_addr_o, if_pc, if_inst, if_valid
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch unit: assembles a 4-byte little-endian instruction from a
// byte-wide memory, presents it to the IF/ID register, and handles stalls
// and redirects. A redirect always wins, discarding any byte accepted in the
// same cycle.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input logic       clk,
  input logic       rst,
  if_fetch_if.master bus
);

  typedef enum logic {
    FETCH = 1'b0,
    OUT   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        k;
  logic [23:0]       byte_buf;

  // Memory request is a pure function of the registered state
  assign bus.mem_req_o  = (state == FETCH);
  assign bus.mem_addr_o = (state == FETCH) ? (pc + ADDR_W'(k)) : pc;

  // Fetch/present state machine with byte assembly and redirect handling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= '0;
      k           <= 2'd0;
      byte_buf    <= 24'd0;
      bus.if_pc    <= '0;
      bus.if_inst  <= '0;
      bus.if_valid <= 1'b0;
    end else if (bus.branch_en_i) begin
      state        <= FETCH;
      pc           <= {bus.branch_target_i[ADDR_W-1:2], 2'b00};
      k            <= 2'd0;
      bus.if_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.mem_valid_i) begin
            k <= k + 2'd1;
            case (k)
              2'd0: byte_buf[7:0]   <= bus.mem_rdata_i;
              2'd1: byte_buf[15:8]  <= bus.mem_rdata_i;
              2'd2: byte_buf[23:16] <= bus.mem_rdata_i;
              default: begin
                state        <= OUT;
                bus.if_pc    <= pc;
                bus.if_inst  <= INST_W'({bus.mem_rdata_i, byte_buf});
                bus.if_valid <= 1'b1;
              end
            endcase
          end
        end
        OUT: begin
          if (!bus.stall_i) begin
            state        <= FETCH;
            pc           <= pc + ADDR_W'(4);
            k            <= 2'd0;
            bus.if_valid <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios (reset, wait states, stall,
// redirect, wrap, async reset) followed by random traffic, all checked
// against a transaction-level model of the fetch unit.
module tb_if_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

  if_fetch #(.ADDR_W(32), .INST_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: current instruction PC, number of bytes collected
  // (4 means the instruction is being presented), and last presented word
  logic [31:0] mPc;
  int          mGot;
  logic [31:0] mLastPc;
  logic [31:0] mLastInst;

  // Byte memory: the program prefix at 0..3, a hash everywhere else
  function automatic logic [7:0] memByte(input logic [31:0] a);
    case (a)
      32'd0: memByte = 8'h13;
      32'd1: memByte = 8'h05;
      32'd2: memByte = 8'h10;
      32'd3: memByte = 8'h00;
      default: memByte = (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    memWord = {memByte(a + 32'd3), memByte(a + 32'd2),
               memByte(a + 32'd1), memByte(a)};
  endfunction

  always_comb bus.mem_rdata_i = memByte(bus.mem_addr_o);

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPc = 32'd0;
    mGot = 0;
    mLastPc = 32'd0;
    mLastInst = 32'd0;
  endtask

  // One clock edge of the model, given the inputs present before the edge
  task automatic modelStep(input logic st, input logic br,
                           input logic [31:0] tgt, input logic mv);
    if (rst) modelReset();
    else if (br) begin
      mPc = tgt & ~32'd3;
      mGot = 0;
    end else if (mGot < 4) begin
      if (mv) begin
        mGot++;
        if (mGot == 4) begin
          mLastPc = mPc;
          mLastInst = memWord(mPc);
        end
      end
    end else if (!st) begin
      mPc = mPc + 32'd4;
      mGot = 0;
    end
  endtask

  task automatic compareAll();
    checkOutput("mem_req", {31'd0, bus.mem_req_o}, {31'd0, mGot < 4});
    checkOutput("mem_addr", bus.mem_addr_o, (mGot < 4) ? mPc + mGot : mPc);
    checkOutput("if_valid", {31'd0, bus.if_valid}, {31'd0, mGot == 4});
    checkOutput("if_pc", bus.if_pc, mLastPc);
    checkOutput("if_inst", bus.if_inst, mLastInst);
  endtask

  // Drive inputs at the falling edge, advance one clock, compare at the next falling edge
  task automatic applyStimulus(input logic st, input logic br,
                               input logic [31:0] tgt, input logic mv);
    bus.stall_i = st;
    bus.branch_en_i = br;
    bus.branch_target_i = tgt;
    bus.mem_valid_i = mv;
    @(posedge clk);
    modelStep(st, br, tgt, mv);
    @(negedge clk);
    compareAll();
  endtask

  logic [31:0] heldPc;
  logic [31:0] heldInst;

  initial begin
    bus.stall_i = 1'b0;
    bus.branch_en_i = 1'b0;
    bus.branch_target_i = 32'd0;
    bus.mem_valid_i = 1'b0;
    modelReset();

    // Reset state and first instruction
    #3;
    compareAll();
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("rst_seq_addr", bus.mem_addr_o, 32'(i));
      applyStimulus(0, 0, 0, 1);
    end
    checkOutput("first_valid", {31'd0, bus.if_valid}, 32'd1);
    checkOutput("first_inst", bus.if_inst, 32'h00100513);
    checkOutput("first_pc", bus.if_pc, 32'h0);

    // Wait states at byte address 6
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("wait_addr", bus.mem_addr_o, 32'h6);
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("wait_addr_end", bus.mem_addr_o, 32'h6);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wait_inst", bus.if_inst, memWord(32'h4));

    // Stall while presenting the instruction at 0x4
    heldPc = bus.if_pc;
    heldInst = bus.if_inst;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 1);
      checkOutput("stall_valid", {31'd0, bus.if_valid}, 32'd1);
      checkOutput("stall_pc", bus.if_pc, 32'h4);
      checkOutput("stall_req", {31'd0, bus.mem_req_o}, 32'd0);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("post_stall_addr", bus.mem_addr_o, 32'h8);

    // Redirect to 0x103 on the cycle the last byte is accepted
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 32'h103, 1);
    checkOutput("redir_valid", {31'd0, bus.if_valid}, 32'd0);
    checkOutput("redir_addr", bus.mem_addr_o, 32'h100);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("redir_pc", bus.if_pc, 32'h100);

    // Redirect to the top of memory and wrap
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_addr", bus.mem_addr_o, 32'h0);

    // Asynchronous reset between edges with two bytes collected
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_req", {31'd0, bus.mem_req_o}, 32'd1);
    checkOutput("arst_addr", bus.mem_addr_o, 32'h0);
    checkOutput("arst_valid", {31'd0, bus.if_valid}, 32'd0);
    checkOutput("arst_pc", bus.if_pc, 32'h0);
    checkOutput("arst_inst", bus.if_inst, 32'h0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    compareAll();
    applyStimulus(0, 0, 0, 1);
    checkOutput("arst_restart", bus.mem_addr_o, 32'h1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic st, br, mv;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 19) == 0);
      mv  = ($urandom_range(0, 9) < 7);
      tgt = $urandom;
      applyStimulus(st, br, tgt, mv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
